// File: rtl/alert_arbiter.sv
// Round-robin arbiter that shares one alert path between NUM_CH detector channels.
// Optional macro ALERT_ARB_OVERFLOW_EN adds a per-channel overflow output.
module alert_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CHAN_W   = 2,
    parameter int unsigned COOLDOWN = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] alert_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CHAN_W-1:0] out_chan,
    output logic [NUM_CH-1:0] pending,
    output logic              busy
`ifdef ALERT_ARB_OVERFLOW_EN
    ,
    output logic [NUM_CH-1:0] overflow
`endif
);

    typedef enum logic [1:0] {StIdle, StOffer, StCool} state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] prev_q, pend_q, pend_d, rise, clr;
    logic [CHAN_W-1:0] chan_q, chan_d, last_q, last_d;
    logic [CHAN_W-1:0] pick, cand;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, found;

    assign rise   = alert_in & ~prev_q;
    assign accept = (state_q == StOffer) && out_ready;
    assign clr    = accept ? (NUM_CH'(1) << chan_q) : '0;
    // A fresh edge on the channel being cleared keeps it pending.
    assign pend_d = (pend_q & ~clr) | rise;

    // Search starts just after the last grant so it becomes lowest priority.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CHAN_W'((32'(last_q) + i) % NUM_CH);
            if (!found && pend_q[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    chan_d  = pick;
                    last_d  = pick;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (out_ready) begin
                    if (COOLDOWN == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StCool;
                        cnt_d   = CNT_W'(COOLDOWN);
                    end
                end
            end
            StCool: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            prev_q  <= '0;
            pend_q  <= '0;
            chan_q  <= '0;
            last_q  <= CHAN_W'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= alert_in;
            pend_q  <= pend_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == StOffer);
    assign out_chan  = chan_q;
    assign pending   = pend_q;
    assign busy      = (state_q != StIdle);

`ifdef ALERT_ARB_OVERFLOW_EN
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    // An edge on an already-pending channel is lost unless that channel is being cleared.
    assign ovf_d = (ovf_q | (rise & pend_q)) & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alert_arbiter.sv
// Scoreboard bench for alert_arbiter: a per-cycle reference model predicts grants,
// a monitor pops and compares them at each handshake.
module tb_alert_arbiter;

    localparam int NUM_CH   = 4;
    localparam int CHAN_W   = 2;
    localparam int COOLDOWN = 3;
    localparam int CNT_W    = 4;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] alert_in;
    logic              out_ready;
    logic              out_valid;
    logic [CHAN_W-1:0] out_chan;
    logic [NUM_CH-1:0] pending;
    logic              busy;
`ifdef ALERT_ARB_OVERFLOW_EN
    logic [NUM_CH-1:0] overflow;
`endif

    alert_arbiter #(
        .NUM_CH  (NUM_CH),
        .CHAN_W  (CHAN_W),
        .COOLDOWN(COOLDOWN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .alert_in (alert_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_chan (out_chan),
        .pending  (pending),
        .busy     (busy)
`ifdef ALERT_ARB_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int busy_cnt = 0;
    int gcount[NUM_CH];
    int exp_q[$];

    // Reference model state, as the spec describes it.
    bit [NUM_CH-1:0] m_prev, m_pend, m_ovf;
    int m_last, m_offer, m_cool;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_last  = NUM_CH - 1;
        m_offer = -1;
        m_cool  = 0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit [NUM_CH-1:0] a, input bit r);
        bit [NUM_CH-1:0] rise;
        bit [NUM_CH-1:0] clr;
        rise = a & ~m_prev;
        clr  = '0;
        if (m_cool > 0) begin
            m_cool--;
        end else if (m_offer >= 0) begin
            if (r) begin
                exp_q.push_back(m_offer);
                clr[m_offer] = 1'b1;
                m_offer = -1;
                m_cool  = COOLDOWN;
            end
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                int c;
                c = (m_last + i) % NUM_CH;
                if (m_pend[c]) begin
                    m_offer = c;
                    m_last  = c;
                    break;
                end
            end
        end
        m_ovf  = (m_ovf | (rise & m_pend)) & ~clr;
        m_pend = (m_pend & ~clr) | rise;
        m_prev = a;
    endtask

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(m_offer >= 0));
        if (m_offer >= 0) chk("out_chan", 32'(out_chan), 32'(m_offer));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("busy", 32'(busy), 32'((m_offer >= 0) || (m_cool > 0)));
`ifdef ALERT_ARB_OVERFLOW_EN
        chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
        if (busy) busy_cnt++;
    endtask

    task automatic cyc(input logic [NUM_CH-1:0] a, input logic r);
        @(negedge clk);
        check_state();
        alert_in  = a;
        out_ready = r;
        model_step(a, r);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        alert_in  = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_step('0, 1'b0);
    endtask

    task automatic clr_counts();
        busy_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) gcount[i] = 0;
    endtask

    // Monitor: a handshake is visible between negedge and the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(out_chan), 32'hffff_ffff);
                end else begin
                    chk("grant_chan", 32'(out_chan), 32'(exp_q.pop_front()));
                end
                if (int'(out_chan) < NUM_CH) gcount[out_chan]++;
            end
        end
    end

    initial begin
        clr_counts();
        do_reset();

        // Single pulse on channel 2: two-cycle latency, busy for 1 + COOLDOWN cycles.
        clr_counts();
        cyc(4'b0100, 1'b1);
        for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'(1 + COOLDOWN));
        chk("t1_grants_ch2", 32'(gcount[2]), 32'd1);

        // All channels at once: round-robin 0,1,2,3.
        clr_counts();
        cyc(4'b1111, 1'b1);
        for (int i = 0; i < 24; i++) cyc(4'b0000, 1'b1);
        for (int i = 0; i < NUM_CH; i++) chk("t2_one_grant_each", 32'(gcount[i]), 32'd1);

        // Stall during OFFER on channel 1.
        clr_counts();
        cyc(4'b0010, 1'b0);
        for (int i = 0; i < 12; i++) cyc(4'b0000, 1'b0);
        chk("t3_no_grant_stalled", 32'(gcount[1]), 32'd0);
        for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b1);
        chk("t3_single_accept", 32'(gcount[1]), 32'd1);

        // Held-high level yields exactly one grant.
        clr_counts();
        for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b1);
        for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b1);
        chk("t4_held_level", 32'(gcount[0]), 32'd1);

        // Channel 3 re-pulses on the acceptance edge, then a pulse while pending.
        clr_counts();
        cyc(4'b1000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b1000, 1'b1);
        cyc(4'b0000, 1'b0);
        cyc(4'b1000, 1'b0);
        cyc(4'b0000, 1'b0);
        for (int i = 0; i < 14; i++) cyc(4'b0000, 1'b1);
        chk("t5_regrant_ch3", 32'(gcount[3]), 32'd2);

        // Reset in the middle of an OFFER with pending 1010.
        cyc(4'b1010, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        #3;
        chk("t6_offer_before_rst", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_valid_async", 32'(out_valid), 32'd0);
        chk("t6_pending_async", 32'(pending), 32'd0);
        do_reset();
        clr_counts();
        cyc(4'b1000, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0001, 1'b1);
        for (int i = 0; i < 14; i++) cyc(4'b0000, 1'b1);
        chk("t6_ch3_after_rst", 32'(gcount[3]), 32'd1);
        chk("t6_ch0_after_rst", 32'(gcount[0]), 32'd1);

        // Randomized traffic with occasional resets.
        begin
            logic [NUM_CH-1:0] a;
            a = '0;
            for (int i = 0; i < 1500; i++) begin
                for (int b = 0; b < NUM_CH; b++)
                    if ($urandom_range(0, 5) == 0) a[b] = ~a[b];
                if ($urandom_range(0, 299) == 0) begin
                    @(negedge clk);
                    do_reset();
                    a = '0;
                end else begin
                    cyc(a, 1'($urandom_range(0, 2) != 0));
                end
            end
        end

        for (int i = 0; i < 40; i++) cyc(4'b0000, 1'b1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_pending", 32'(pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alert_arbiter.md
Name: alert_arbiter

Overview:
- Shares one alert-reporting path (status LED / host interface) between NUM_CH sequence-detector channels.
- Captures rising edges of each detector's alert output as sticky pending flags.
- Grants channels in round-robin order and presents one channel ID at a time over a valid/ready handshake.
- Enforces a programmable cooldown between services so a downstream consumer (display, UART formatter) is never flooded.

Parameters:
- NUM_CH, 4, number of detector channels; 2 <= NUM_CH <= 2**CHAN_W.
- CHAN_W, 2, width of the channel-ID output.
- COOLDOWN, 3, idle cycles inserted after each accepted grant; 0 disables the cooldown.
- CNT_W, 4, cooldown counter width; COOLDOWN < 2**CNT_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- alert_in  in  NUM_CH  level alert from each detector; bit i = channel i.
- out_ready  in  1  consumer accepts the offered channel this cycle.
- out_valid  out  1  a channel ID is being offered.
- out_chan  out  CHAN_W  ID of the offered channel; valid only while out_valid=1.
- pending  out  NUM_CH  sticky pending flags, one per channel.
- busy  out  1  high in OFFER or COOL.

Behaviour:
- Reset: clk and reset follow the decided rule: one clock; reset asynchronous, active-high.
  - While reset=1: state=IDLE; out_valid=0; out_chan=0; pending=0; busy=0; alert_in history=0; last_grant=NUM_CH-1, so channel 0 wins first; cooldown count=0.
- Edge capture: alert_in is registered once as prev.
  - Rising edge on bit i (alert_in[i]=1, prev[i]=0) sets pending[i] at that clock edge.
  - A held-high level sets pending only once.
- States:
  - IDLE: if pending != 0, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_CH. Register it into out_chan and last_grant; go to OFFER. Otherwise stay in IDLE.
  - OFFER: out_valid=1; out_chan is held stable until the handshake.
    - On out_valid & out_ready: clear pending[out_chan]; go to COOL, loading count=COOLDOWN.
    - If COOLDOWN=0, go to IDLE instead.
  - COOL: count decrements each cycle; at count==1 go to IDLE. out_valid=0.
- Latency: alert_in rises before clock edge k → pending set after edge k → out_valid=1 after edge k+1. Minimum 2 cycles.
- Throughput: one grant per (2 + COOLDOWN) cycles when out_ready is held high.
- Simultaneous events:
  - Rising edge on channel c in the same cycle its grant is accepted: pending[c] stays 1. The new set wins over the clear.
  - Edges on other channels during OFFER or COOL accumulate in pending; they do not disturb out_chan.
- Fairness: a channel that has just been granted is lowest priority on the next search.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-OFFER: out_valid drops asynchronously; pending events are discarded.
- Unused ID encodings (>= NUM_CH) are never produced.

Optional Feature:
- Macro: ALERT_ARB_OVERFLOW_EN.
- When defined: adds output port overflow [NUM_CH].
  - overflow[i] sets when a rising edge on channel i arrives while pending[i] is already 1 and is not being cleared in that cycle.
  - overflow[i] clears when channel i's grant is accepted, unless a new overflow occurs in the same cycle.
  - Reset value 0.
- When undefined: the port and its logic are absent; repeated edges on a pending channel are silently merged.

Test Plan:
- Reset, then pulse alert_in=4'b0100 for 1 cycle, out_ready=1 → pending=4'b0100 one cycle later; out_valid=1 with out_chan=2 one cycle after that; pending=0 after the handshake; busy high for exactly 1+3 cycles.
- alert_in=4'b1111 in one cycle, out_ready=1, COOLDOWN=3 → grants in order 0,1,2,3, each 5 cycles apart; pending ends 0.
- out_ready=0 for 10 cycles during OFFER on channel 1 → out_valid and out_chan=1 held all 10 cycles. Raise out_ready → single acceptance, then COOL.
- alert_in[0] held high for 20 cycles → exactly one grant for channel 0.
- Channel 3 re-pulses in the same cycle its grant is accepted → pending[3] remains 1; a second grant of channel 3 follows after cooldown. With ALERT_ARB_OVERFLOW_EN, a pulse while pending → overflow[3]=1 until the next acceptance.
- Assert reset mid-OFFER with pending=4'b1010 → out_valid=0 and pending=0 immediately. After release, a pulse on channel 3 is granted first (last_grant reset).
